// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, fetches via req/ready, issues via valid/ack, halts on EBREAK/timeout/misalign
module pc_fetch_sequencer #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ack,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_imm,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic [1:0]      halt_cause,
  output logic [31:0]     retired
);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d, target;
  logic [31:0] instr_q, instr_d, retired_q, retired_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] cause_q, cause_d;
  logic accept;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    instr_pc_d = instr_pc_q;
    retired_d = retired_q;
    wait_cnt_d = wait_cnt_q;
    cause_d = cause_q;
    accept = instr_ack & ~stall;
    target = instr_pc_q + (branch_taken ? (branch_imm << 1) : XLEN'(4));
    case (state_q)
      IDLE: begin
        pc_d = RESET_PC;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          instr_pc_d = pc_q;
          wait_cnt_d = '0;
          state_d = ISSUE;
        end else if (wait_cnt_q == 8'(MAX_WAIT - 1)) begin
          state_d = HALT;
          cause_d = 2'b10;
        end else wait_cnt_d = wait_cnt_q + 8'd1;
      end
      ISSUE: begin
        if (accept) begin
          retired_d = retired_q + 32'd1;
          if (instr_q == EBREAK) begin
            state_d = HALT;
            cause_d = 2'b01;
          end else if (target[1:0] != 2'b00) begin
            state_d = HALT;
            cause_d = 2'b11;
          end else begin
            pc_d = target;
            state_d = FETCH;
          end
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      instr_q <= '0;
      instr_pc_q <= '0;
      retired_q <= '0;
      wait_cnt_q <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      instr_pc_q <= instr_pc_d;
      retired_q <= retired_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q <= cause_d;
    end
  end
  assign imem_req = state_q == FETCH;
  assign imem_addr = state_q == FETCH ? pc_q : '0;
  assign instr_valid = state_q == ISSUE;
  assign instr = instr_q;
  assign instr_pc = instr_pc_q;
  assign pc = pc_q;
  assign halted = state_q == HALT;
  assign halt_cause = cause_q;
  assign retired = retired_q;
endmodule
